// File: rtl/rpi_bus_pkg.sv
// Shared defaults and width helpers for the RPi parallel-bus slave.
package rpi_bus_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int RX_DEPTH_DEF = 16;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rpi_bus_fifo.sv
// Synchronous first-word-fall-through FIFO with registered occupancy count.
module rpi_bus_fifo
    import rpi_bus_pkg::*;
#(
    parameter  int WIDTH = DATA_W_DEF,
    parameter  int DEPTH = RX_DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push_ok = i_push & (~o_full | i_pop);
    assign w_pop_ok  = i_pop & ~o_empty;

    // NOTE: storage has no reset; pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rpi_bus_if.sv
// RPi parallel-bus slave: synchronised strobe, RX FIFO stream, TX holding register, LEDs.
// Define RPI_BUS_LOOPBACK_EN to feed RX FIFO bytes straight back to RPi reads.
module rpi_bus_if
    import rpi_bus_pkg::*;
#(
    parameter  int DATA_W      = DATA_W_DEF,
    parameter  int RX_DEPTH    = RX_DEPTH_DEF,
    parameter  int SYNC_STAGES = 2,
    parameter  int LED_W       = 4,
    localparam int CW          = cnt_w(RX_DEPTH)
) (
    input  logic              clk_100mhz,
    input  logic              reset_n,
    input  logic              bus_clk,
    input  logic              bus_rnw,
    input  logic [DATA_W-1:0] bus_data_in,
    output logic [DATA_W-1:0] bus_data_out,
    output logic              bus_data_oe,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [CW-1:0]     rx_count,
    output logic [LED_W-1:0]  led_out,
    output logic              rx_overflow,
    output logic              tx_underflow
);

    localparam int               ARM_W   = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_rnw_sync;
    logic [DATA_W-1:0]      r_data_sync [SYNC_STAGES];
    logic                   r_clk_d;
    logic [ARM_W-1:0]       r_arm_cnt;
    logic [DATA_W-1:0]      r_tx_hold;
    logic                   r_tx_valid;
    logic [LED_W-1:0]       r_led;
    logic                   r_ovf;
    logic                   r_udf;

    logic                   w_clk_s;
    logic                   w_rnw_s;
    logic [DATA_W-1:0]      w_data_s;
    logic                   w_armed;
    logic                   w_wr;
    logic                   w_rd;
    logic                   w_full;
    logic                   w_empty;
    logic [DATA_W-1:0]      w_head;
    logic                   w_fifo_pop;
    logic                   w_tx_load;
    logic [DATA_W-1:0]      w_tx_data;
    logic                   w_unused;

    assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
    assign w_rnw_s  = r_rnw_sync[SYNC_STAGES-1];
    assign w_data_s = r_data_sync[SYNC_STAGES-1];
    assign w_armed  = (r_arm_cnt == ARM_MAX);
    assign w_wr     = w_armed & w_clk_s & ~r_clk_d & ~w_rnw_s;
    assign w_rd     = w_armed & ~w_clk_s & r_clk_d & w_rnw_s;

    always_ff @(posedge clk_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_sync <= '0;
            r_rnw_sync <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) r_data_sync[i] <= '0;
            r_clk_d    <= 1'b0;
            r_arm_cnt  <= '0;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], bus_clk};
            r_rnw_sync <= {r_rnw_sync[SYNC_STAGES-2:0], bus_rnw};
            r_data_sync[0] <= bus_data_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_data_sync[i] <= r_data_sync[i-1];
            r_clk_d    <= w_clk_s;
            // Edges stay masked until a bus_clk held through reset has reached clk_d.
            if (!w_armed) r_arm_cnt <= r_arm_cnt + 1'b1;
        end
    end

`ifdef RPI_BUS_LOOPBACK_EN
    assign w_fifo_pop = ~r_tx_valid & ~w_empty;
    assign w_tx_load  = w_fifo_pop;
    assign w_tx_data  = w_head;
    assign m_valid    = 1'b0;
    assign s_ready    = 1'b0;
    assign w_unused   = ^{s_data, s_valid, m_ready};
`else
    assign w_fifo_pop = m_ready & ~w_empty;
    assign w_tx_load  = s_valid & ~r_tx_valid;
    assign w_tx_data  = s_data;
    assign m_valid    = ~w_empty;
    assign s_ready    = ~r_tx_valid;
    assign w_unused   = 1'b0;
`endif

    rpi_bus_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk     (clk_100mhz),
        .rst_n   (reset_n),
        .i_push  (w_wr),
        .i_data  (w_data_s),
        .i_pop   (w_fifo_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (rx_count)
    );

    always_ff @(posedge clk_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_hold  <= '0;
            r_tx_valid <= 1'b0;
            r_led      <= '0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
        end else begin
            if (w_tx_load) begin
                r_tx_hold  <= w_tx_data;
                r_tx_valid <= 1'b1;
            end else if (w_rd && r_tx_valid) begin
                r_tx_valid <= 1'b0;
            end
            if (w_rd && !r_tx_valid)              r_udf <= 1'b1;
            if (w_wr)                             r_led <= w_data_s[LED_W-1:0];
            if (w_wr && w_full && !w_fifo_pop)    r_ovf <= 1'b1;
        end
    end

    assign m_data       = w_head;
    assign bus_data_oe  = w_rnw_s;
    assign bus_data_out = r_tx_valid ? r_tx_hold : '0;
    assign led_out      = r_led;
    assign rx_overflow  = r_ovf;
    assign tx_underflow = r_udf;

endmodule

// File: tb/tb_rpi_bus_if.sv
// Directed bench for rpi_bus_if with a transaction-level model checked every settled cycle.
module tb_rpi_bus_if;

    localparam int DW     = 8;
    localparam int DEPTH  = 16;
    localparam int S      = 2;
    localparam int LW     = 4;
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int SETTLE = S + 4;

    logic          clk_100mhz = 1'b0;
    logic          reset_n    = 1'b0;
    logic          bus_clk    = 1'b0;
    logic          bus_rnw    = 1'b0;
    logic [DW-1:0] bus_data_in = '0;
    logic [DW-1:0] bus_data_out;
    logic          bus_data_oe;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] s_data  = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [CW-1:0] rx_count;
    logic [LW-1:0] led_out;
    logic          rx_overflow;
    logic          tx_underflow;

    always #5 clk_100mhz = ~clk_100mhz;

    rpi_bus_if #(
        .DATA_W      (DW),
        .RX_DEPTH    (DEPTH),
        .SYNC_STAGES (S),
        .LED_W       (LW)
    ) dut (
        .clk_100mhz   (clk_100mhz),
        .reset_n      (reset_n),
        .bus_clk      (bus_clk),
        .bus_rnw      (bus_rnw),
        .bus_data_in  (bus_data_in),
        .bus_data_out (bus_data_out),
        .bus_data_oe  (bus_data_oe),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .rx_count     (rx_count),
        .led_out      (led_out),
        .rx_overflow  (rx_overflow),
        .tx_underflow (tx_underflow)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: bytes held by the RX FIFO, the TX byte on offer, and the sticky flags.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_tx;
    logic [LW-1:0] m_led;
    bit            m_txv, m_ovf, m_udf, m_rnw;
    bit            cmp_en = 1'b0;
    int            mv_cycles = 0;
    logic [DW-1:0] pop_log[$];

    function automatic void model_reset();
        mq.delete();
        m_tx  = '0;
        m_led = '0;
        m_txv = 1'b0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endfunction

    // In loopback the holding register refills itself from the oldest written byte.
    function automatic void model_loopback();
`ifdef RPI_BUS_LOOPBACK_EN
        if (!m_txv && mq.size() > 0) begin
            m_tx  = mq.pop_front();
            m_txv = 1'b1;
        end
`endif
    endfunction

    always @(negedge clk_100mhz) begin
        if (m_valid) mv_cycles++;
`ifdef RPI_BUS_LOOPBACK_EN
        if (reset_n) check("lb_m_valid_low", 32'(m_valid), 32'(0));
`endif
        if (cmp_en) begin
            check("rx_count", 32'(rx_count), 32'(mq.size()));
            check("led_out", 32'(led_out), 32'(m_led));
            check("rx_overflow", 32'(rx_overflow), 32'(m_ovf));
            check("tx_underflow", 32'(tx_underflow), 32'(m_udf));
            check("bus_data_oe", 32'(bus_data_oe), 32'(m_rnw));
            check("bus_data_out", 32'(bus_data_out), m_txv ? 32'(m_tx) : 32'(0));
`ifndef RPI_BUS_LOOPBACK_EN
            check("m_valid", 32'(m_valid), 32'(mq.size() != 0));
            check("s_ready", 32'(s_ready), 32'(!m_txv));
            if (mq.size() != 0) check("m_data_head", 32'(m_data), 32'(mq[0]));
`else
            check("lb_s_ready", 32'(s_ready), 32'(0));
`endif
        end
        if (reset_n && m_valid && m_ready) begin
            pop_log.push_back(m_data);
            if (mq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected: got m_data 0x%0h while model holds no byte", m_data);
            end else begin
                check("pop_data", 32'(m_data), 32'(mq.pop_front()));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_100mhz);
        #1;
    endtask

    task automatic bus_write(input logic [DW-1:0] b);
        cmp_en      = 1'b0;
        bus_rnw     = 1'b0;
        m_rnw       = 1'b0;
        bus_data_in = b;
        cycles(SETTLE);
        bus_clk = 1'b1;
        m_led   = b[LW-1:0];
        if (mq.size() < DEPTH) mq.push_back(b);
        else                   m_ovf = 1'b1;
        cycles(SETTLE);
        bus_clk = 1'b0;
        cycles(SETTLE);
        model_loopback();
        cmp_en = 1'b1;
    endtask

    task automatic bus_read(output logic [DW-1:0] got);
        cmp_en  = 1'b0;
        bus_rnw = 1'b1;
        m_rnw   = 1'b1;
        cycles(SETTLE);
        check("rd_oe", 32'(bus_data_oe), 32'(1));
        bus_clk = 1'b1;
        cycles(SETTLE);
        got = bus_data_out;
        check("rd_data", 32'(got), m_txv ? 32'(m_tx) : 32'(0));
        bus_clk = 1'b0;
        cycles(SETTLE);
        if (m_txv) m_txv = 1'b0;
        else       m_udf = 1'b1;
        model_loopback();
        cmp_en = 1'b1;
        cycles(2);
        cmp_en  = 1'b0;
        bus_rnw = 1'b0;
        m_rnw   = 1'b0;
        cycles(SETTLE);
        cmp_en = 1'b1;
    endtask

    task automatic tx_load(input logic [DW-1:0] b);
        int n = 0;
        while (!s_ready && n < 50) begin
            cycles(1);
            n++;
        end
        check("tx_ready_wait", 32'(s_ready), 32'(1));
        cmp_en  = 1'b0;
        s_data  = b;
        s_valid = 1'b1;
        cycles(1);
        s_valid = 1'b0;
        m_tx    = b;
        m_txv   = 1'b1;
        cmp_en  = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] got;
        logic [DW-1:0] got2;

        model_reset();
        m_rnw = 1'b0;
        cycles(3);
        check("rst_m_valid", 32'(m_valid), 32'(0));
        check("rst_rx_count", 32'(rx_count), 32'(0));
        check("rst_led", 32'(led_out), 32'(0));
        check("rst_oe", 32'(bus_data_oe), 32'(0));
        check("rst_data_out", 32'(bus_data_out), 32'(0));
        check("rst_flags", 32'({rx_overflow, tx_underflow}), 32'(0));
        reset_n = 1'b1;
        cycles(SETTLE);
        cmp_en = 1'b1;

`ifndef RPI_BUS_LOOPBACK_EN
        // Single write drained immediately by a ready consumer.
        m_ready   = 1'b1;
        mv_cycles = 0;
        pop_log.delete();
        bus_write(8'hA5);
        cycles(4);
        m_ready = 1'b0;
        check("a5_pops", 32'(pop_log.size()), 32'(1));
        if (pop_log.size() > 0) check("a5_data", 32'(pop_log[0]), 32'h0000_00A5);
        check("a5_valid_cycles", 32'(mv_cycles), 32'(1));
        check("a5_led", 32'(led_out), 32'h5);
        check("a5_count", 32'(rx_count), 32'(0));

        // Seventeen writes into a sixteen-entry FIFO, then drain.
        for (int i = 0; i <= 16; i++) bus_write(DW'(i));
        check("ovf_count", 32'(rx_count), 32'(16));
        check("ovf_flag", 32'(rx_overflow), 32'(1));
        check("ovf_led", 32'(led_out), 32'h0);
        pop_log.delete();
        m_ready = 1'b1;
        cycles(24);
        m_ready = 1'b0;
        check("drain_len", 32'(pop_log.size()), 32'(16));
        for (int i = 0; i < 16 && i < pop_log.size(); i++)
            check("drain_order", 32'(pop_log[i]), 32'(i));
        check("drain_count", 32'(rx_count), 32'(0));
        check("ovf_sticky", 32'(rx_overflow), 32'(1));

        // TX byte returned on a read strobe.
        tx_load(8'h3C);
        check("tx_ready_low", 32'(s_ready), 32'(0));
        bus_read(got);
        check("tx_read_3c", 32'(got), 32'h3C);
        check("tx_ready_back", 32'(s_ready), 32'(1));
        check("tx_udf_clear", 32'(tx_underflow), 32'(0));

        // Read with nothing held.
        bus_read(got);
        check("udf_data", 32'(got), 32'(0));
        check("udf_flag", 32'(tx_underflow), 32'(1));
        cycles(5);
        check("udf_sticky", 32'(tx_underflow), 32'(1));
`else
        mv_cycles = 0;
        bus_write(8'h11);
        bus_write(8'h22);
        bus_read(got);
        bus_read(got2);
        check("lb_read_1", 32'(got), 32'h11);
        check("lb_read_2", 32'(got2), 32'h22);
        check("lb_no_m_valid", 32'(mv_cycles), 32'(0));
`endif

        // bus_clk held high across reset release must not register as a write.
        cmp_en      = 1'b0;
        reset_n     = 1'b0;
        bus_clk     = 1'b1;
        bus_rnw     = 1'b0;
        m_rnw       = 1'b0;
        bus_data_in = 8'hEE;
        model_reset();
        mv_cycles = 0;
        cycles(3);
        reset_n = 1'b1;
        cmp_en  = 1'b1;
        cycles(SETTLE);
        bus_clk = 1'b0;
        cycles(SETTLE);
        check("rsthi_count", 32'(rx_count), 32'(0));
        check("rsthi_led", 32'(led_out), 32'(0));
        check("rsthi_no_valid", 32'(mv_cycles), 32'(0));
        check("rsthi_flags", 32'({rx_overflow, tx_underflow}), 32'(0));

        cycles(4);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
